ddr_read_phase_cal: RTL and testbench
=====================================

// Module: ddr_read_phase_cal
// PURPOSE
//  Drives the PLL read-clock phase-step interface (phase_step/phase_updn) of the DDR clocking block.
//  Sweeps every phase tap, runs one read-compare trial per tap, and finds the longest passing window
//  (circular). Then steps the read clock to the window centre.
//  Sits in the clk_ddrMgmt domain between the DDR clocking block and the read-training datapath.
// PARAMETERS
//  NUM_PHASES   16    phase taps per 360 deg; power of 2, 4..32
//  PULSE_CYC    4     cycles phase_step is held high per step request (>=1)
//  SETTLE_CYC   64    cycles waited after each step before checking locked (>=1)
//  TIMEOUT_CYC  1024  trial-response timeout; only used with DDR_PHASE_CAL_TIMEOUT_EN
// PORTS
//  clk            in   1        management clock
//  rst_n          in   1        asynchronous active-low reset
//  start          in   1        1-cycle pulse; starts calibration when idle (ignored while busy)
//  locked         in   1        PLL lock; must be 1 before each trial
//  trial_req      out  1        1-cycle pulse: run one read-compare at current phase
//  trial_valid    in   1        1-cycle pulse: trial result available
//  trial_pass     in   1        trial result, sampled when trial_valid=1
//  phase_step     out  1        step request to PLL, high for PULSE_CYC cycles
//  phase_updn     out  1        step direction: 1=+1 tap, 0=-1 tap; stable whenever phase_step=1
//  pass_map       out  NUM_PHASES  per-tap trial result; bit i = tap i relative to start phase
//  win_start      out  $clog2(NUM_PHASES)  first tap of best window
//  win_len        out  $clog2(NUM_PHASES)+1  length of best window
//  cal_phase      out  $clog2(NUM_PHASES)  final tap relative to start phase
//  busy           out  1        high from the cycle after start until DONE/FAIL
//  done           out  1        sticky; calibration succeeded
//  fail           out  1        sticky; calibration failed
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, tap counter=0. rst_n asserted mid-sweep aborts immediately.
//   No step is completed; the PLL phase is left wherever it reached.
//  start in IDLE/DONE/FAIL: clear done, fail, pass_map. busy=1 next cycle. tap=0. Go to WAIT_LOCK.
//  WAIT_LOCK: wait for locked=1. Then go to TRIAL_REQ.
//  TRIAL_REQ: drive trial_req=1 for exactly 1 cycle. Go to TRIAL_WAIT.
//  TRIAL_WAIT: on trial_valid, pass_map[tap]<=trial_pass.
//   If tap==NUM_PHASES-1, go to ANALYSE. Otherwise go to STEP with updn=1.
//   trial_valid in any other state is ignored.
//  STEP: phase_step=1 for PULSE_CYC cycles. Tap counter moves +/-1 mod NUM_PHASES at the pulse end.
//   Then go to SETTLE. phase_updn is set 1 cycle before phase_step rises and held until the pulse ends.
//  SETTLE: wait SETTLE_CYC cycles. Then go to WAIT_LOCK (sweep) or MOVE (centering).
//  ANALYSE: scans the 2*NUM_PHASES circular bit sequence at 1 bit/cycle, tracking the longest run of 1s.
//   Run length saturates at NUM_PHASES. On a tie, the lowest win_start wins.
//   Takes exactly 2*NUM_PHASES cycles.
//   win_len==0 -> FAIL.
//   win_len==NUM_PHASES -> target=0.
//   Otherwise target = (win_start + (win_len-1)/2) mod NUM_PHASES (integer floor).
//  Return path: the phase was never stepped back after the last sweep tap, so it sits at NUM_PHASES-1.
//   Required moves to target d: forward distance f=(target-(NUM_PHASES-1)) mod NUM_PHASES.
//   If f<=NUM_PHASES/2, step up f times. Otherwise step down NUM_PHASES-f times.
//  MOVE: issue STEP/SETTLE until tap==target, wait for locked=1, then go to DONE.
//  DONE: cal_phase<=target, done=1, busy=0. FAIL: fail=1, busy=0, cal_phase unchanged.
//  locked dropping during SETTLE/WAIT_LOCK only delays the FSM; it does not fail.
//  start while busy: ignored. start and trial_valid in the same cycle: trial_valid is ignored.
// CONFIGURATION
//  DDR_PHASE_CAL_TIMEOUT_EN defined: counter runs in TRIAL_WAIT and WAIT_LOCK.
//   After TIMEOUT_CYC cycles with no trial_valid/locked, go to FAIL.
//  Not defined: no timeout logic. The FSM waits indefinitely. TIMEOUT_CYC is unused.
// TESTING
//  1 Reset asserted mid-STEP -> phase_step=0, busy=0, all outputs 0 asynchronously.
//  2 start, pass on taps 5..9 only -> win_start=5, win_len=5, target=7.
//    15->7: f=8<=8, so 8 up-steps. cal_phase=7, done=1.
//  3 start, pass on taps 14,15,0,1 -> win_start=14, win_len=4, target=15.
//    0 move steps. done=1, cal_phase=15.
//  4 start, all trials fail -> pass_map=0, fail=1, done=0, zero move steps.
//  5 Ties: pass on taps 1,2 and 9,10 -> win_start=1, target=1.
//    15->1: f=2, so 2 up-steps. done=1.
//  6 TIMEOUT_EN: trial_valid never returned -> fail=1 exactly TIMEOUT_CYC cycles after trial_req.
//    Without macro: busy stays 1.

Source files
------------

// File: rtl/ddr_read_phase_cal.sv
// DDR read-clock phase calibration: sweep all PLL taps, centre on best pass window.
// Optional trial/lock timeout enabled by defining DDR_PHASE_CAL_TIMEOUT_EN.
module ddr_read_phase_cal #(
  parameter int NUM_PHASES  = 16,
  parameter int PULSE_CYC   = 4,
  parameter int SETTLE_CYC  = 64,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic                            locked,
  output logic                            trial_req,
  input  logic                            trial_valid,
  input  logic                            trial_pass,
  output logic                            phase_step,
  output logic                            phase_updn,
  output logic [NUM_PHASES-1:0]           pass_map,
  output logic [$clog2(NUM_PHASES)-1:0]   win_start,
  output logic [$clog2(NUM_PHASES):0]     win_len,
  output logic [$clog2(NUM_PHASES)-1:0]   cal_phase,
  output logic                            busy,
  output logic                            done,
  output logic                            fail
);

  localparam int TW = $clog2(NUM_PHASES);
  localparam int LW = TW + 1;
  localparam int M1 = (SETTLE_CYC > TIMEOUT_CYC) ? SETTLE_CYC : TIMEOUT_CYC;
  localparam int M2 = (M1 > 2*NUM_PHASES) ? M1 : 2*NUM_PHASES;
  localparam int M3 = (M2 > PULSE_CYC) ? M2 : PULSE_CYC;
  localparam int CW = $clog2(M3) + 1;

  typedef enum logic [3:0] {
    S_IDLE, S_WAIT_LOCK, S_TRIAL_REQ, S_TRIAL_WAIT,
    S_STEP_SETUP, S_STEP, S_SETTLE, S_ANALYSE,
    S_CALC, S_MOVE, S_DONE, S_FAIL
  } state_t;

  state_t        state;
  logic [TW-1:0] tap;
  logic [TW-1:0] target;
  logic [CW-1:0] cnt;
  logic [LW-1:0] run;
  logic [TW-1:0] run_start;
  logic          moving;
  logic          mv_up;

  logic [TW-1:0] idx;
  logic [LW-1:0] run_inc;
  logic [TW-1:0] run_first;
  logic [TW-1:0] tgt_c;
  logic [TW-1:0] fwd;
  logic          up_c;
  logic          timeout;

  assign idx       = cnt[TW-1:0];
  assign run_inc   = (run == LW'(NUM_PHASES)) ? run : run + 1'b1;
  assign run_first = (run == '0) ? idx : run_start;
  assign tgt_c     = (win_len == LW'(NUM_PHASES)) ? '0 :
                     win_start + TW'((win_len - 1'b1) >> 1);
  // Phase sits at the last tap after the sweep; forward distance is target+1.
  assign fwd       = tgt_c + 1'b1;
  assign up_c      = ({1'b0, fwd} <= LW'(NUM_PHASES/2));

`ifdef DDR_PHASE_CAL_TIMEOUT_EN
  assign timeout = (cnt == CW'(TIMEOUT_CYC-1));
`else
  assign timeout = 1'b0;
`endif

  // Calibration sequencer: sweep, analyse, centre; all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      tap        <= '0;
      target     <= '0;
      cnt        <= '0;
      run        <= '0;
      run_start  <= '0;
      moving     <= 1'b0;
      mv_up      <= 1'b0;
      trial_req  <= 1'b0;
      phase_step <= 1'b0;
      phase_updn <= 1'b0;
      pass_map   <= '0;
      win_start  <= '0;
      win_len    <= '0;
      cal_phase  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      fail       <= 1'b0;
    end else begin
      trial_req <= 1'b0;
      unique case (state)
        S_IDLE, S_DONE, S_FAIL: begin
          if (start) begin
            done     <= 1'b0;
            fail     <= 1'b0;
            pass_map <= '0;
            busy     <= 1'b1;
            tap      <= '0;
            moving   <= 1'b0;
            cnt      <= '0;
            state    <= S_WAIT_LOCK;
          end
        end
        S_WAIT_LOCK: begin
          cnt <= cnt + 1'b1;
          if (locked) begin
            cnt <= '0;
            if (moving) begin
              cal_phase <= target;
              done      <= 1'b1;
              busy      <= 1'b0;
              state     <= S_DONE;
            end else begin
              trial_req <= 1'b1;
              state     <= S_TRIAL_REQ;
            end
          end else if (timeout) begin
            fail  <= 1'b1;
            busy  <= 1'b0;
            state <= S_FAIL;
          end
        end
        S_TRIAL_REQ: begin
          cnt   <= CW'(1);
          state <= S_TRIAL_WAIT;
        end
        S_TRIAL_WAIT: begin
          cnt <= cnt + 1'b1;
          if (trial_valid) begin
            pass_map[tap] <= trial_pass;
            cnt           <= '0;
            if (tap == TW'(NUM_PHASES-1)) begin
              run       <= '0;
              win_len   <= '0;
              win_start <= '0;
              state     <= S_ANALYSE;
            end else begin
              phase_updn <= 1'b1;
              state      <= S_STEP_SETUP;
            end
          end else if (timeout) begin
            fail  <= 1'b1;
            busy  <= 1'b0;
            state <= S_FAIL;
          end
        end
        S_STEP_SETUP: begin
          phase_step <= 1'b1;
          cnt        <= '0;
          state      <= S_STEP;
        end
        S_STEP: begin
          if (cnt == CW'(PULSE_CYC-1)) begin
            phase_step <= 1'b0;
            tap        <= phase_updn ? tap + 1'b1 : tap - 1'b1;
            cnt        <= '0;
            state      <= S_SETTLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_SETTLE: begin
          if (cnt == CW'(SETTLE_CYC-1)) begin
            cnt   <= '0;
            state <= moving ? S_MOVE : S_WAIT_LOCK;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_ANALYSE: begin
          if (pass_map[idx]) begin
            run       <= run_inc;
            run_start <= run_first;
            if (run_inc > win_len) begin
              win_len   <= run_inc;
              win_start <= run_first;
            end
          end else begin
            run <= '0;
          end
          if (cnt == CW'(2*NUM_PHASES-1)) begin
            cnt   <= '0;
            state <= S_CALC;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_CALC: begin
          if (win_len == '0) begin
            fail  <= 1'b1;
            busy  <= 1'b0;
            state <= S_FAIL;
          end else begin
            target <= tgt_c;
            mv_up  <= up_c;
            moving <= 1'b1;
            state  <= S_MOVE;
          end
        end
        S_MOVE: begin
          if (tap == target) begin
            cnt   <= '0;
            state <= S_WAIT_LOCK;
          end else begin
            phase_updn <= mv_up;
            state      <= S_STEP_SETUP;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ddr_read_phase_cal.sv
// Directed bench for ddr_read_phase_cal.
// Covers reset, window centring, wrap, fail, ties, down moves, timeout.
module tb_ddr_read_phase_cal;

  localparam int N = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic locked = 1'b1;
  logic trial_valid = 1'b0;
  logic trial_pass = 1'b0;
  logic trial_req;
  logic phase_step;
  logic phase_updn;
  logic [N-1:0] pass_map;
  logic [3:0] win_start;
  logic [4:0] win_len;
  logic [3:0] cal_phase;
  logic busy;
  logic done;
  logic fail;

  int checks = 0;
  int fails = 0;
  logic [N-1:0] pat = '0;
  bit resp_en = 1'b0;
  int tidx = 0;
  int up_cnt = 0;
  int dn_cnt = 0;
  int viol = 0;
  int up0 = 0;
  int dn0 = 0;
  logic prev_step = 1'b0;
  logic prev_updn = 1'b0;

  always #5 clk = ~clk;

  ddr_read_phase_cal dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .locked      (locked),
    .trial_req   (trial_req),
    .trial_valid (trial_valid),
    .trial_pass  (trial_pass),
    .phase_step  (phase_step),
    .phase_updn  (phase_updn),
    .pass_map    (pass_map),
    .win_start   (win_start),
    .win_len     (win_len),
    .cal_phase   (cal_phase),
    .busy        (busy),
    .done        (done),
    .fail        (fail)
  );

  // Trial responder: answers each trial_req two cycles later from pat.
  initial forever begin
    @(negedge clk);
    if (start && !busy) tidx = 0;
    if (trial_req === 1'b1 && resp_en) begin
      @(posedge clk);
      #1;
      trial_valid = 1'b1;
      trial_pass  = pat[tidx[3:0]];
      tidx++;
      @(posedge clk);
      #1;
      trial_valid = 1'b0;
      trial_pass  = 1'b0;
    end
  end

  // Step monitor: counts up/down pulses, flags direction instability.
  always @(negedge clk) begin
    if (phase_step && !prev_step) begin
      if (phase_updn) up_cnt++;
      else dn_cnt++;
      if (phase_updn !== prev_updn) viol++;
    end else if (phase_step && phase_updn !== prev_updn) begin
      viol++;
    end
    prev_step = phase_step;
    prev_updn = phase_updn;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic pulse_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_end();
    int n;
    n = 0;
    while (n < 10000 && !(done || fail)) begin
      @(negedge clk);
      n++;
    end
    chk("end_in_budget", 32'(n < 10000), 32'd1);
  endtask

  task automatic run(input logic [N-1:0] p);
    pat = p;
    up0 = up_cnt;
    dn0 = dn_cnt;
    pulse_start();
    wait_end();
  endtask

  initial begin
    int n;
    resp_en = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_fail", 32'(fail), 32'd0);
    chk("rst_trial_req", 32'(trial_req), 32'd0);
    chk("rst_step", 32'(phase_step), 32'd0);
    chk("rst_updn", 32'(phase_updn), 32'd0);
    chk("rst_pass_map", 32'(pass_map), 32'd0);
    chk("rst_win_len", 32'(win_len), 32'd0);
    chk("rst_cal_phase", 32'(cal_phase), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset asserted in the middle of a step pulse
    pat = 16'hFFFF;
    pulse_start();
    @(negedge clk);
    chk("t1_busy_after_start", 32'(busy), 32'd1);
    n = 0;
    while (n < 500 && !phase_step) begin
      @(negedge clk);
      n++;
    end
    chk("t1_step_seen", 32'(phase_step), 32'd1);
    chk("t1_map_bit0", 32'(pass_map), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("t1_async_step", 32'(phase_step), 32'd0);
    chk("t1_async_busy", 32'(busy), 32'd0);
    chk("t1_async_map", 32'(pass_map), 32'd0);
    chk("t1_async_updn", 32'(phase_updn), 32'd0);
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b1;

    // Window 5..9, with ignored start and a lock drop mid-sweep
    pat = 16'h03E0;
    up0 = up_cnt;
    dn0 = dn_cnt;
    viol = 0;
    pulse_start();
    repeat (300) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    locked = 1'b0;
    repeat (200) @(posedge clk);
    #1 locked = 1'b1;
    wait_end();
    chk("t2_done", 32'(done), 32'd1);
    chk("t2_fail", 32'(fail), 32'd0);
    chk("t2_busy", 32'(busy), 32'd0);
    chk("t2_map", 32'(pass_map), 32'h03E0);
    chk("t2_win_start", 32'(win_start), 32'd5);
    chk("t2_win_len", 32'(win_len), 32'd5);
    chk("t2_cal", 32'(cal_phase), 32'd7);
    chk("t2_up", 32'(up_cnt - up0), 32'd23);
    chk("t2_dn", 32'(dn_cnt - dn0), 32'd0);
    chk("t2_updn_stable", 32'(viol), 32'd0);

    // Wrapping window 14,15,0,1
    run(16'hC003);
    chk("t3_done", 32'(done), 32'd1);
    chk("t3_win_start", 32'(win_start), 32'd14);
    chk("t3_win_len", 32'(win_len), 32'd4);
    chk("t3_cal", 32'(cal_phase), 32'd15);
    chk("t3_up", 32'(up_cnt - up0), 32'd15);
    chk("t3_dn", 32'(dn_cnt - dn0), 32'd0);

    // All trials fail
    run(16'h0000);
    chk("t4_fail", 32'(fail), 32'd1);
    chk("t4_done", 32'(done), 32'd0);
    chk("t4_busy", 32'(busy), 32'd0);
    chk("t4_map", 32'(pass_map), 32'd0);
    chk("t4_win_len", 32'(win_len), 32'd0);
    chk("t4_cal_kept", 32'(cal_phase), 32'd15);
    chk("t4_up", 32'(up_cnt - up0), 32'd15);
    chk("t4_dn", 32'(dn_cnt - dn0), 32'd0);

    // Tie between 1,2 and 9,10: lowest start wins
    run(16'h0606);
    chk("t5_done", 32'(done), 32'd1);
    chk("t5_fail", 32'(fail), 32'd0);
    chk("t5_win_start", 32'(win_start), 32'd1);
    chk("t5_win_len", 32'(win_len), 32'd2);
    chk("t5_cal", 32'(cal_phase), 32'd1);
    chk("t5_up", 32'(up_cnt - up0), 32'd17);

    // Window 10..12: target 11 reached by 4 down-steps
    run(16'h1C00);
    chk("t7_done", 32'(done), 32'd1);
    chk("t7_win_start", 32'(win_start), 32'd10);
    chk("t7_win_len", 32'(win_len), 32'd3);
    chk("t7_cal", 32'(cal_phase), 32'd11);
    chk("t7_up", 32'(up_cnt - up0), 32'd15);
    chk("t7_dn", 32'(dn_cnt - dn0), 32'd4);

    // Every tap passes: full-circle window, target 0
    run(16'hFFFF);
    chk("t8_done", 32'(done), 32'd1);
    chk("t8_win_start", 32'(win_start), 32'd0);
    chk("t8_win_len", 32'(win_len), 32'd16);
    chk("t8_cal", 32'(cal_phase), 32'd0);
    chk("t8_up", 32'(up_cnt - up0), 32'd16);

    // Trial never answered
    resp_en = 1'b0;
    pulse_start();
    n = 0;
    while (n < 100 && trial_req !== 1'b1) begin
      @(negedge clk);
      n++;
    end
    chk("t6_trial_req_seen", 32'(trial_req), 32'd1);
`ifdef DDR_PHASE_CAL_TIMEOUT_EN
    n = 0;
    while (n < 2000 && !fail) begin
      @(negedge clk);
      n++;
    end
    chk("t6_timeout_cycles", 32'(n), 32'd1024);
    chk("t6_fail", 32'(fail), 32'd1);
    chk("t6_busy", 32'(busy), 32'd0);
`else
    repeat (1500) @(negedge clk);
    chk("t6_busy_held", 32'(busy), 32'd1);
    chk("t6_no_fail", 32'(fail), 32'd0);
    chk("t6_no_done", 32'(done), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
